decoder_scan_nto2n: RTL and testbench

//   Parametrised, registered N-to-2^N one-hot decoder with an internal scan mode.

---
 rtl/decoder_scan_nto2n.sv | 141 ++++++++++++++
 tb/tb_decoder_scan_nto2n.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_nto2n.sv
// decoder_scan_nto2n: registered N-to-2^N one-hot (or one-cold) decoder.
// Direct mode registers the decoded select input. Scan mode sweeps every
// output in turn, once per div_i+1 cycles, to drive multiplexed digit selects.
// Optional feature macro: DECODER_BLANK_EN. It inserts a blanking interval
// after each scan step (all outputs inactive for min(BLANK_CYC, div_i+1)
// cycles). With the macro undefined there is no BLANK state and BLANK_CYC is
// ignored.
module decoder_scan_nto2n #(
  parameter  int SEL_W      = 3,
  parameter  int DIV_W      = 16,
  parameter  int ACTIVE_LOW = 0,
  parameter  int BLANK_CYC  = 4,
  localparam int OUT_W      = 2 ** SEL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [SEL_W-1:0] signal_i,
  output logic [OUT_W-1:0] signal_o,
  output logic [SEL_W-1:0] index_o,
  output logic             step_o
);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
`ifdef DECODER_BLANK_EN
    SCAN,
    BLANK
`else
    SCAN
`endif
  } state_t;

  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  if (BLANK_CYC < 0) begin : g_bad_blank_cyc
    $error("BLANK_CYC must be non-negative");
  end

  state_t           state, state_n;
  logic [DIV_W-1:0] counter, counter_n;
  logic [SEL_W-1:0] index_n;
  logic [OUT_W-1:0] signal_n;
  logic             step_n;

  // Active bit for index idx, with every other bit at the inactive level.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] hot;
    hot      = '0;
    hot[idx] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~hot : hot;
  endfunction

`ifdef DECODER_BLANK_EN
  // Cycles already spent in the current step once this edge has counted,
  // widened so the compare against BLANK_CYC cannot wrap.
  logic [31:0] elapsed;
  assign elapsed = 32'(counter) + 32'd1;
`endif

  // State and output registers; every output is registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      counter  <= '0;
      index_o  <= '0;
      signal_o <= INACTIVE;
      step_o   <= 1'b0;
    end else begin
      state    <= state_n;
      counter  <= counter_n;
      index_o  <= index_n;
      signal_o <= signal_n;
      step_o   <= step_n;
    end
  end

  // Next-state and next-output selection from enable, mode and divider.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    index_n   = index_o;
    signal_n  = signal_o;
    step_n    = 1'b0;

    if (!en_i) begin
      state_n  = IDLE;
      signal_n = INACTIVE;
    end else if (!mode_i) begin
      state_n   = DIRECT;
      counter_n = '0;
      index_n   = signal_i;
      signal_n  = decode(signal_i);
    end else if (state == IDLE || state == DIRECT) begin
      // Scan always restarts at index 0 rather than resuming.
      state_n   = SCAN;
      counter_n = '0;
      index_n   = '0;
      signal_n  = decode('0);
    end else if (counter >= div_i) begin
      // Terminal count; also catches div_i lowered below the running count.
      counter_n = '0;
      index_n   = index_o + 1'b1;
      step_n    = 1'b1;
`ifdef DECODER_BLANK_EN
      if (BLANK_CYC == 0) begin
        state_n  = SCAN;
        signal_n = decode(index_n);
      end else begin
        state_n  = BLANK;
        signal_n = INACTIVE;
      end
`else
      state_n  = SCAN;
      signal_n = decode(index_n);
`endif
    end else begin
      counter_n = counter + 1'b1;
`ifdef DECODER_BLANK_EN
      // Blanking runs on the divider itself, so a period shorter than
      // BLANK_CYC simply stays blank until the next step.
      if (state == BLANK) begin
        if (elapsed >= 32'(BLANK_CYC)) begin
          state_n  = SCAN;
          signal_n = decode(index_o);
        end else begin
          signal_n = INACTIVE;
        end
      end else begin
        signal_n = decode(index_o);
      end
`else
      signal_n = decode(index_o);
`endif
    end
  end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench for decoder_scan_nto2n: stimulus pushes hand-computed
// expectations, a monitor pops and compares one entry per clock. An
// ACTIVE_LOW=1 instance shares the inputs and must show the inverted pattern.
module tb_decoder_scan_nto2n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] div = '0;
  logic [2:0]  sel = '0;
  logic [7:0]  sig_hi, sig_lo;
  logic [2:0]  idx_hi, idx_lo;
  logic        step_hi, step_lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         chk;
    logic [7:0] sig;
    logic [2:0] idx;
    logic       step;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_scan_nto2n #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(0), .BLANK_CYC(4)) u_hi (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .div_i(div),
    .signal_i(sel), .signal_o(sig_hi), .index_o(idx_hi), .step_o(step_hi)
  );

  decoder_scan_nto2n #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1), .BLANK_CYC(4)) u_lo (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .div_i(div),
    .signal_i(sel), .signal_o(sig_lo), .index_o(idx_lo), .step_o(step_lo)
  );

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] oh(input int i);
    return 8'h01 << (i % 8);
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic step_in(input logic e, input logic m, input logic [15:0] d,
                         input logic [2:0] s, input bit c, input logic [7:0] es,
                         input int ei, input logic est, input string nm);
    exp_t x;
    @(negedge clk);
    en = e; mode = m; div = d; sel = s;
    x.chk = c; x.sig = es; x.idx = 3'(ei); x.step = est; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: one expectation per clock, sampled just after the active edge.
  initial begin
    exp_t       x;
    logic [7:0] inv;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.chk) begin
          inv = ~x.sig;
          cmp({x.name, "/sig"},     32'(sig_hi),  32'(x.sig));
          cmp({x.name, "/sig_lo"},  32'(sig_lo),  32'(inv));
          cmp({x.name, "/idx"},     32'(idx_hi),  32'(x.idx));
          cmp({x.name, "/idx_lo"},  32'(idx_lo),  32'(x.idx));
          cmp({x.name, "/step"},    32'(step_hi), 32'(x.step));
          cmp({x.name, "/step_lo"}, 32'(step_lo), 32'(x.step));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset asserted mid-clock, before any edge.
    #1 rst_n = 1'b0;
    #1;
    cmp("reset/sig",    32'(sig_hi),  32'h00);
    cmp("reset/sig_lo", 32'(sig_lo),  32'hFF);
    cmp("reset/idx",    32'(idx_hi),  32'h0);
    cmp("reset/step",   32'(step_hi), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step_in(1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 8'h00, 0, 1'b0, "idle_after_reset");

    // Direct decode, one cycle latency.
    for (int i = 0; i < 8; i++)
      step_in(1'b1, 1'b0, 16'd0, 3'(i), 1'b1, oh(i), i, 1'b0, "direct");
    step_in(1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 8'h00, 7, 1'b0, "idle_hold");

`ifndef DECODER_BLANK_EN
    // Scan with div=2: step every 3 cycles, wrap 7 -> 0.
    for (int k = 0; k < 29; k++)
      step_in(1'b1, 1'b1, 16'd2, 3'd0, 1'b1, oh((k / 3) % 8), (k / 3) % 8,
              (k > 0 && k % 3 == 0), "scan_div2");
    // Pause: outputs inactive, index held at 1.
    for (int k = 0; k < 5; k++)
      step_in(1'b0, 1'b1, 16'd2, 3'd0, 1'b1, 8'h00, 1, 1'b0, "scan_paused");
    // Resume restarts from index 0.
    for (int k = 0; k < 4; k++)
      step_in(1'b1, 1'b1, 16'd2, 3'd0, 1'b1, oh((k / 3) % 8), (k / 3) % 8,
              (k > 0 && k % 3 == 0), "scan_resume");
    step_in(1'b1, 1'b0, 16'd2, 3'd5, 1'b1, oh(5), 5, 1'b0, "direct_mid");
    // Scan with div=10 until counter=7, then lower div to 1.
    for (int k = 0; k < 8; k++)
      step_in(1'b1, 1'b1, 16'd10, 3'd0, 1'b1, oh(0), 0, 1'b0, "scan_div10");
    for (int j = 0; j < 7; j++)
      step_in(1'b1, 1'b1, 16'd1, 3'd0, 1'b1, oh(1 + j / 2), 1 + j / 2,
              (j % 2 == 0), "scan_div1");
    // div=0: advance every cycle, step held high.
    for (int j = 0; j < 5; j++)
      step_in(1'b1, 1'b1, 16'd0, 3'd0, 1'b1, oh((5 + j) % 8), (5 + j) % 8,
              1'b1, "scan_div0");
`else
    // div=9: after each step 4 blank cycles then 6 lit cycles.
    for (int k = 0; k < 26; k++)
      step_in(1'b1, 1'b1, 16'd9, 3'd0, 1'b1,
              (k >= 10 && k % 10 < 4) ? 8'h00 : oh((k / 10) % 8), (k / 10) % 8,
              (k > 0 && k % 10 == 0), "blank_div9");
    step_in(1'b1, 1'b0, 16'd2, 3'd0, 1'b1, oh(0), 0, 1'b0, "direct_mid");
    // div=2: period shorter than blanking, dark after the first step.
    for (int k = 0; k < 12; k++)
      step_in(1'b1, 1'b1, 16'd2, 3'd0, 1'b1, (k < 3) ? oh(0) : 8'h00, (k / 3) % 8,
              (k > 0 && k % 3 == 0), "blank_div2");
`endif

    // Reset asserted mid-scan takes effect immediately.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    cmp("reset_mid/sig",    32'(sig_hi),  32'h00);
    cmp("reset_mid/sig_lo", 32'(sig_lo),  32'hFF);
    cmp("reset_mid/idx",    32'(idx_hi),  32'h0);
    cmp("reset_mid/step",   32'(step_hi), 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step_in(1'b1, 1'b1, 16'd3, 3'd0, 1'b1, oh(0), 0, 1'b0, "scan_after_reset");
    step_in(1'b0, 1'b1, 16'd3, 3'd0, 1'b1, 8'h00, 0, 1'b0, "idle_final");

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) cmp("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
